// File: rtl/conv_kxk_mac_requant_if.sv
// Streaming bundle for the KxK MAC/requant processing element: beat input,
// per-group requant sideband, result output and the sticky saturation flag.
interface conv_kxk_mac_requant_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 9
);
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] Feature;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] Weight;
    logic                              in_valid;
    logic                              in_last;
    logic                              in_ready;
    logic signed [31:0]                BIAS;
    logic [31:0]                       Scale;
    logic [7:0]                        Shift;
    logic signed [DATA_WIDTH-1:0]      Zero_Point;
    logic                              relu_en;
    logic signed [DATA_WIDTH-1:0]      RESULT;
    logic                              out_valid;
    logic                              out_ready;
    logic                              sat_flag;

    modport master (
        output Feature, Weight, in_valid, in_last, BIAS, Scale, Shift, Zero_Point, relu_en, out_ready,
        input  in_ready, RESULT, out_valid, sat_flag
    );

    modport slave (
        input  Feature, Weight, in_valid, in_last, BIAS, Scale, Shift, Zero_Point, relu_en, out_ready,
        output in_ready, RESULT, out_valid, sat_flag
    );
endinterface

// File: rtl/conv_kxk_mac_requant.sv
// KxK signed dot product with cross-channel saturating accumulation, followed by
// bias/scale/round-shift/ReLU/zero-point requantisation. One global stall freezes every stage.
module conv_kxk_mac_requant #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 9,
    parameter int ACC_WIDTH   = 32
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    conv_kxk_mac_requant_if.slave  i_bus
);
    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int TREE_W = PROD_W + $clog2(KERNEL_SIZE);
    localparam int SUM_W  = ((ACC_WIDTH > TREE_W) ? ACC_WIDTH : TREE_W) + 1;
    localparam int B4_W   = ((ACC_WIDTH > 32) ? ACC_WIDTH : 32) + 1;
    localparam int M5_W   = B4_W + 32;
    localparam int Z7_W   = M5_W + 1;

    typedef struct packed {
        logic signed [31:0]           bias;
        logic [31:0]                  scale;
        logic [7:0]                   shift;
        logic signed [DATA_WIDTH-1:0] zp;
        logic                         relu;
    } side_t;

    function automatic logic [ACC_WIDTH:0] sat_acc(input logic signed [SUM_W-1:0] v);
        logic [SUM_W-ACC_WIDTH:0] top;
        logic                     ovf;
        logic [ACC_WIDTH-1:0]     val;
        top = v[SUM_W-1:ACC_WIDTH-1];
        ovf = !((&top) || !(|top));
        if (!ovf)         val = v[ACC_WIDTH-1:0];
        else if (top[SUM_W-ACC_WIDTH]) val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else              val = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return {ovf, val};
    endfunction

    function automatic logic [DATA_WIDTH:0] sat_out(input logic signed [Z7_W-1:0] v);
        logic [Z7_W-DATA_WIDTH:0] top;
        logic                     ovf;
        logic [DATA_WIDTH-1:0]    val;
        top = v[Z7_W-1:DATA_WIDTH-1];
        ovf = !((&top) || !(|top));
        if (!ovf)         val = v[DATA_WIDTH-1:0];
        else if (top[Z7_W-DATA_WIDTH]) val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else              val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return {ovf, val};
    endfunction

    // Round half up: bias by 2^(sh-1) before the arithmetic shift; one spare bit absorbs the carry.
    function automatic logic signed [M5_W-1:0] round_shift(input logic signed [M5_W-1:0] v,
                                                           input logic [5:0] sh);
        logic signed [M5_W:0] t;
        t = (M5_W+1)'(v);
        if (sh != 6'd0) t = t + ((M5_W+1)'(1) << (sh - 6'd1));
        t = t >>> sh;
        return t[M5_W-1:0];
    endfunction

    logic                                w_stall, w_en, w_accept;
    side_t                               w_side_in;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0]   r_feat_p0, r_wgt_p0;
    logic                                r_last_p0, r_last_p1, r_last_p2;
    side_t                               r_side_p0, r_side_p1, r_side_p2, r_side_p3;
    logic signed [PROD_W-1:0]            r_prod_p1 [KERNEL_SIZE];
    logic signed [TREE_W-1:0]            w_tree, r_tree_p2;
    logic signed [ACC_WIDTH-1:0]         r_acc, r_acc_p3, w_acc_next;
    logic signed [SUM_W-1:0]             w_acc_sum;
    logic                                w_acc_ovf;
    logic signed [B4_W-1:0]              r_bias_p4;
    logic [31:0]                         r_scale_p4;
    logic [7:0]                          r_shift_p4, r_shift_p5;
    logic signed [DATA_WIDTH-1:0]        r_zp_p4, r_zp_p5, r_zp_p6;
    logic                                r_relu_p4, r_relu_p5;
    logic signed [M5_W-1:0]              r_mult_p5, w_rnd, r_rnd_p6;
    logic [5:0]                          w_sh;
    logic signed [Z7_W-1:0]              w_zp_sum;
    logic signed [DATA_WIDTH-1:0]        w_out_val, r_result_p7;
    logic                                w_out_clamp;
    logic                                r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3;
    logic                                r_vld_p4, r_vld_p5, r_vld_p6, r_vld_p7;
    logic                                r_sat;

    assign w_stall        = r_vld_p7 && !i_bus.out_ready;
    assign w_en           = !w_stall;
    assign i_bus.in_ready = RSTN && !w_stall;
    assign w_accept       = i_bus.in_valid && i_bus.in_ready;

    assign i_bus.RESULT    = r_result_p7;
    assign i_bus.out_valid = r_vld_p7;
    assign i_bus.sat_flag  = r_sat;

    always_comb begin
        w_side_in       = '0;
        w_side_in.bias  = i_bus.BIAS;
        w_side_in.scale = i_bus.Scale;
        w_side_in.shift = i_bus.Shift;
        w_side_in.zp    = i_bus.Zero_Point;
        w_side_in.relu  = i_bus.relu_en;
    end

    always_comb begin
        w_tree = '0;
        for (int i = 0; i < KERNEL_SIZE; i++)
            w_tree = w_tree + TREE_W'(r_prod_p1[i]);
    end

    assign w_acc_sum = SUM_W'(r_acc) + SUM_W'(r_tree_p2);
    assign {w_acc_ovf, w_acc_next} = sat_acc(w_acc_sum);

    assign w_sh = (r_shift_p5 > 8'd63) ? 6'd63 : r_shift_p5[5:0];

    always_comb begin
        w_rnd = round_shift(r_mult_p5, w_sh);
        if (r_relu_p5 && w_rnd[M5_W-1]) w_rnd = '0;
    end

    assign w_zp_sum = Z7_W'(r_rnd_p6) + Z7_W'(r_zp_p6);
    assign {w_out_clamp, w_out_val} = sat_out(w_zp_sum);

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_vld_p0    <= 1'b0;
            r_vld_p1    <= 1'b0;
            r_vld_p2    <= 1'b0;
            r_vld_p3    <= 1'b0;
            r_vld_p4    <= 1'b0;
            r_vld_p5    <= 1'b0;
            r_vld_p6    <= 1'b0;
            r_vld_p7    <= 1'b0;
            r_acc       <= '0;
            r_result_p7 <= '0;
            r_sat       <= 1'b0;
        end else if (w_en) begin
            r_vld_p0 <= w_accept;
            r_vld_p1 <= r_vld_p0;
            r_vld_p2 <= r_vld_p1;
            // Only the last beat of a group continues past the accumulator.
            r_vld_p3 <= r_vld_p2 && r_last_p2;
            r_vld_p4 <= r_vld_p3;
            r_vld_p5 <= r_vld_p4;
            r_vld_p6 <= r_vld_p5;
            r_vld_p7 <= r_vld_p6;
            if (r_vld_p2) r_acc <= r_last_p2 ? '0 : w_acc_next;
            if (r_vld_p6) r_result_p7 <= w_out_val;
            if ((r_vld_p2 && w_acc_ovf) || (r_vld_p6 && w_out_clamp)) r_sat <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_en) begin
            // p0: input capture
            r_feat_p0 <= i_bus.Feature;
            r_wgt_p0  <= i_bus.Weight;
            r_last_p0 <= i_bus.in_last;
            r_side_p0 <= w_side_in;
            // p1: per-tap products
            for (int i = 0; i < KERNEL_SIZE; i++)
                r_prod_p1[i] <= PROD_W'($signed(r_feat_p0[DATA_WIDTH*i +: DATA_WIDTH]))
                              * PROD_W'($signed(r_wgt_p0[DATA_WIDTH*i +: DATA_WIDTH]));
            r_last_p1 <= r_last_p0;
            r_side_p1 <= r_side_p0;
            // p2: adder tree
            r_tree_p2 <= w_tree;
            r_last_p2 <= r_last_p1;
            r_side_p2 <= r_side_p1;
            // p3: group sum forwarded
            r_acc_p3  <= w_acc_next;
            r_side_p3 <= r_side_p2;
            // p4: bias
            r_bias_p4  <= B4_W'(r_acc_p3) + B4_W'(r_side_p3.bias);
            r_scale_p4 <= r_side_p3.scale;
            r_shift_p4 <= r_side_p3.shift;
            r_zp_p4    <= r_side_p3.zp;
            r_relu_p4  <= r_side_p3.relu;
            // p5: scale
            r_mult_p5  <= M5_W'(r_bias_p4) * M5_W'($signed({1'b0, r_scale_p4}));
            r_shift_p5 <= r_shift_p4;
            r_zp_p5    <= r_zp_p4;
            r_relu_p5  <= r_relu_p4;
            // p6: round, shift, ReLU
            r_rnd_p6 <= w_rnd;
            r_zp_p6  <= r_zp_p5;
        end
    end
endmodule

// File: tb/tb_conv_kxk_mac_requant.sv
// Directed bench for conv_kxk_mac_requant: expected results queued at issue,
// popped and compared by a monitor whenever an output handshake occurs.
module tb_conv_kxk_mac_requant;
    localparam int DW = 8;
    localparam int K  = 9;

    logic CLK = 1'b0;
    logic RSTN;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   n_push = 0;
    int   q_exp[$];

    always #5 CLK = ~CLK;

    conv_kxk_mac_requant_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K)) bus ();

    conv_kxk_mac_requant #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .ACC_WIDTH(32)) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .i_bus (bus)
    );

    function automatic logic [DW*K-1:0] rep(input int v);
        logic [DW*K-1:0] r;
        for (int i = 0; i < K; i++) r[DW*i +: DW] = 8'(v);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic set_rq(input int bias, input int scale, input int sh, input int zp, input logic relu);
        bus.BIAS       = 32'(bias);
        bus.Scale      = 32'(scale);
        bus.Shift      = 8'(sh);
        bus.Zero_Point = 8'(zp);
        bus.relu_en    = relu;
    endtask

    task automatic beat(input int f, input int w, input logic last);
        int t;
        bus.Feature  = rep(f);
        bus.Weight   = rep(w);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!bus.in_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic group1(input int f, input int w, input int exp);
        q_exp.push_back(exp);
        n_push++;
        beat(f, w, 1'b1);
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (q_exp.size() != 0 && t < 200) begin
            @(posedge CLK);
            t++;
        end
        #1;
        chk(nm, q_exp.size(), 0);
    endtask

    task automatic monitor();
        int e;
        forever begin
            @(negedge CLK);
            if (RSTN && bus.out_valid && bus.out_ready) begin
                n_out++;
                if (q_exp.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0d, required no output", $signed(bus.RESULT));
                end else begin
                    e = q_exp.pop_front();
                    chk("result", int'($signed(bus.RESULT)), e);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        RSTN         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.Feature  = '0;
        bus.Weight   = '0;
        bus.out_ready = 1'b1;
        set_rq(0, 1, 0, 0, 1'b0);
        fork
            monitor();
        join_none

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_result", int'($signed(bus.RESULT)), 0);
        chk("rst_sat_flag", int'(bus.sat_flag), 0);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;

        // Single beat sum 9 with latency measurement
        set_rq(0, 1, 0, 0, 1'b0);
        group1(1, 1, 9);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        chk("latency", lat, 7);
        drain("drain_t1");
        chk("sat_before_clamp", int'(bus.sat_flag), 0);

        // Three beats of 54, bias -12 -> 150 clamps to 127
        set_rq(-12, 1, 0, 0, 1'b0);
        beat(2, 3, 1'b0);
        beat(2, 3, 1'b0);
        group1(2, 3, 127);
        drain("drain_t2");
        chk("sat_after_clamp", int'(bus.sat_flag), 1);

        // Rounding, back-to-back with sideband changes between groups
        set_rq(0, 3, 2, 63, 1'b0);
        group1(1, 1, 70);
        set_rq(0, 1, 1, 63, 1'b0);
        group1(1, 1, 68);
        set_rq(0, 1, 0, 63, 1'b1);
        group1(1, -1, 63);
        set_rq(0, 1, 0, 63, 1'b0);
        group1(1, -1, 54);
        set_rq(0, 1, 200, 5, 1'b0);
        group1(1, 1, 5);
        set_rq(0, 1, 1, 0, 1'b0);
        group1(1, -1, -4);
        set_rq(0, 1, 0, 0, 1'b0);
        group1(127, -128, -128);
        set_rq(0, 32'hFFFF_FFFF, 32, 0, 1'b0);
        group1(1, 1, 9);
        drain("drain_t3");

        // Stream of single-beat groups with downstream stall
        set_rq(0, 1, 0, 0, 1'b0);
        fork
            begin
                for (int k = 1; k <= 12; k++) group1(k, 1, 9 * k);
            end
            begin
                repeat (8) @(posedge CLK);
                #1;
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge CLK);
                    chk("stall_out_valid", int'(bus.out_valid), 1);
                    chk("stall_in_ready", int'(bus.in_ready), 0);
                end
                @(posedge CLK);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("drain_t5");

        // Reset mid-group discards partial sum
        set_rq(0, 1, 0, 0, 1'b0);
        beat(1, 1, 1'b0);
        beat(1, 1, 1'b0);
        RSTN = 1'b0;
        #1;
        chk("midrst_in_ready", int'(bus.in_ready), 0);
        @(posedge CLK);
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_result", int'($signed(bus.RESULT)), 0);
        chk("midrst_sat_flag", int'(bus.sat_flag), 0);
        RSTN = 1'b1;
        group1(1, 1, 9);
        drain("drain_t6");

        repeat (12) @(posedge CLK);
        #1;
        chk("output_count", n_out, n_push);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
